// File: rtl/secure_serdes_decryptor_core.sv
// Receive-side SERDES decryptor: deserializes cipher and B-share streams MSB first
// and presents cipher ^ B ^ KEY on a valid/ready byte interface.
module secure_serdes_decryptor_core #(
  parameter logic [7:0] KEY = 8'h34
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cipher_bit,
  input  logic       b_bit,
  input  logic       plain_ready,
  output logic [7:0] plain_out,
  output logic       plain_valid,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DECRYPT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] c_reg;
  logic [7:0] b_reg;
  logic [2:0] bit_cnt;
  logic       handshake;

  assign handshake = (state == HOLD) && plain_valid && plain_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (bit_cnt == 3'd7) state_next = DECRYPT;
      DECRYPT: state_next = HOLD;
      HOLD:    if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: shift registers, output byte and handshake flags follow the FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_reg       <= 8'd0;
      b_reg       <= 8'd0;
      bit_cnt     <= 3'd0;
      plain_out   <= 8'd0;
      plain_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            c_reg   <= 8'd0;
            b_reg   <= 8'd0;
            bit_cnt <= 3'd0;
            done    <= 1'b0;
          end
        end
        SHIFT: begin
          c_reg   <= {c_reg[6:0], cipher_bit};
          b_reg   <= {b_reg[6:0], b_bit};
          bit_cnt <= bit_cnt + 3'd1;
        end
        DECRYPT: begin
          plain_out   <= c_reg ^ b_reg ^ KEY;
          plain_valid <= 1'b1;
          bit_cnt     <= 3'd0;
        end
        HOLD: begin
          if (handshake) begin
            plain_valid <= 1'b0;
            done        <= 1'b1;
          end
        end
        default: begin
          plain_valid <= 1'b0;
        end
      endcase
    end
  end

  // A start seen while a frame is in flight is flagged but never disturbs that frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (start && (state != IDLE)) begin
      overrun <= 1'b1;
    end
  end

endmodule
